// File: rtl/aes_pkg.sv
// Shared types and GF(2^8) helpers for the sequential AES MixColumns engine.
package aes_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
   endfunction

   // Constant multipliers needed by MixColumns/InvMixColumns; anything else is treated as 1.
   function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] k);
      logic [7:0] x2, x4, x8, r;
      x2 = xtime(b);
      x4 = xtime(x2);
      x8 = xtime(x4);
      r  = b;
      case (k)
         4'h2: r = x2;
         4'h3: r = x2 ^ b;
         4'h9: r = x8 ^ b;
         4'hB: r = x8 ^ x2 ^ b;
         4'hD: r = x8 ^ x4 ^ b;
         4'hE: r = x8 ^ x4 ^ x2;
         default: r = b;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] col_of(input logic [127:0] s, input logic [1:0] c);
      logic [31:0] r;
      r = s[127:96];
      case (c)
         2'd0: r = s[127:96];
         2'd1: r = s[95:64];
         2'd2: r = s[63:32];
         2'd3: r = s[31:0];
         default: r = s[127:96];
      endcase
      return r;
   endfunction

   function automatic logic [7:0] byte_of(input logic [31:0] col, input logic [1:0] r);
      logic [7:0] b;
      b = col[31:24];
      case (r)
         2'd0: b = col[31:24];
         2'd1: b = col[23:16];
         2'd2: b = col[15:8];
         2'd3: b = col[7:0];
         default: b = col[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/aes_mix_columns_seq_if.sv
// Block-in / block-out handshake bundle for the MixColumns engine.
interface aes_mix_columns_seq_if;
   // A transfer happens on a rising edge where valid and ready are both high; the
   // sender holds data stable while valid is high and ready is low.
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_block;
   logic         in_inv;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_block;

   modport master (
      output in_valid, in_block, in_inv, in_bypass, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_block, in_inv, in_bypass, out_ready,
      output in_ready, out_valid, out_block
   );
endinterface

// File: rtl/aes_mix_col32.sv
// Combinational single-column MixColumns / InvMixColumns.
module aes_mix_col32
   import aes_pkg::*;
(
   input  logic [31:0] col,
   input  logic        inv,
   output logic [31:0] result
);

   logic [7:0] a [4];
   logic [7:0] o [4];

   for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int R1 = (r + 1) % 4;
      localparam int R2 = (r + 2) % 4;
      localparam int R3 = (r + 3) % 4;
      assign a[r] = byte_of(col, 2'(r));
      assign o[r] = inv ? (gf_mul(a[r], 4'hE) ^ gf_mul(a[R1], 4'hB) ^
                           gf_mul(a[R2], 4'hD) ^ gf_mul(a[R3], 4'h9))
                        : (gf_mul(a[r], 4'h2) ^ gf_mul(a[R1], 4'h3) ^
                           a[R2] ^ a[R3]);
   end

   assign result = {o[0], o[1], o[2], o[3]};

endmodule

// File: rtl/aes_mix_columns_seq.sv
// Handshaked AES MixColumns/InvMixColumns engine: COLS_PER_CYCLE columns per cycle, in place.
module aes_mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   aes_mix_columns_seq_if.slave  bus,
   output state_e                fsm_state
);

   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
      $error("aes_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_CNT = 2'(4 - COLS_PER_CYCLE);

   state_e       state, state_next;
   logic [1:0]   col_cnt;
   logic [127:0] work;
   logic [127:0] work_next;
   logic         mode_inv, mode_byp;
   logic         accept, busy;

   logic [31:0]  lane_in  [4];
   logic [31:0]  lane_wr  [4];
   logic [31:0]  col_next [4];

   assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
   assign bus.out_valid = (state == DONE);
   assign bus.out_block = work;
   assign accept        = bus.in_valid && bus.in_ready;
   assign busy          = (state == BUSY);
   assign fsm_state     = state;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = BUSY;
         BUSY:    if (col_cnt == LAST_CNT) state_next = DONE;
         DONE:    if (bus.out_ready) state_next = accept ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Lane k works on column col_cnt+k; lanes beyond COLS_PER_CYCLE are never selected.
   for (genvar k = 0; k < 4; k++) begin : g_lane
      assign lane_in[k] = col_of(work, col_cnt + 2'(k));
      if (k < COLS_PER_CYCLE) begin : g_mix
         logic [31:0] mixed;
         aes_mix_col32 u_mix (
            .col    (lane_in[k]),
            .inv    (mode_inv),
            .result (mixed)
         );
         assign lane_wr[k] = mode_byp ? lane_in[k] : mixed;
      end else begin : g_idle
         assign lane_wr[k] = lane_in[k];
      end
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [1:0] offset;
      logic       active;
      assign offset      = 2'(c) - col_cnt;
      assign active      = busy && ({1'b0, offset} < 3'(COLS_PER_CYCLE));
      assign col_next[c] = accept ? col_of(bus.in_block, 2'(c)) :
                           active ? lane_wr[offset] : col_of(work, 2'(c));
   end

   assign work_next = {col_next[0], col_next[1], col_next[2], col_next[3]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         col_cnt  <= 2'd0;
         work     <= 128'h0;
         mode_inv <= 1'b0;
         mode_byp <= 1'b0;
      end else begin
         state <= state_next;
         work  <= work_next;
         if (accept) begin
            col_cnt  <= 2'd0;
            mode_inv <= bus.in_inv;
            mode_byp <= bus.in_bypass;
         end else if (busy) begin
            col_cnt  <= col_cnt + STEP;
         end
      end
   end

endmodule
